// File: rtl/int_pkg.sv
// Shared definitions for the P7 interrupt responder and the bridge decode that
// routes handler acknowledge writes to it.
package int_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ASSERT  = 2'd1,
        S_HOLDOFF = 2'd2,
        S_DONE    = 2'd3
    } int_state_t;

    localparam logic [31:0] INT_ACK_ADDR_DEFAULT  = 32'h0000_7f20;
    localparam logic [31:0] INT_TARGET_PC_DEFAULT = 32'h0000_3010;

    localparam int FIRE_CNT_W = 8;
    localparam int TMO_CNT_W  = 16;

    // Word-granular address compare: byte offset bits [1:0] never take part.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return ((a ^ b) & ~32'h0000_0003) == 32'h0000_0000;
    endfunction

endpackage

// File: rtl/pc_rise_detect.sv
// Registers the PC-vs-target comparison and flags the first cycle of a match,
// so a PC stalled on the target produces a single trigger.
module pc_rise_detect
    import int_pkg::*;
#(
    parameter logic [31:0] TARGET_PC = INT_TARGET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_pc,
    output logic        o_rise
);

    logic w_match;
    logic r_match_q;

    assign w_match = word_match(i_pc, TARGET_PC);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) r_match_q <= 1'b0;
        else       r_match_q <= w_match;
    end

    assign o_rise = w_match & ~r_match_q;

endmodule

// File: rtl/int_responder.sv
// Device-side interrupt source: raises interrupt when the CPU reaches TARGET_PC,
// holds it until the handler acknowledges, then holds off before re-arming.
module int_responder
    import int_pkg::*;
#(
    parameter logic [31:0] ACK_ADDR    = INT_ACK_ADDR_DEFAULT,
    parameter logic [31:0] TARGET_PC   = INT_TARGET_PC_DEFAULT,
    parameter int unsigned FIRE_LIMIT  = 1,
    parameter int unsigned HOLDOFF     = 4,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           macroscopic_pc,
    input  logic [31:0]           m_int_addr,
    input  logic [3:0]            m_int_byteen,
    output logic                  interrupt,
    output logic [FIRE_CNT_W-1:0] fire_count,
    output logic                  ack_timeout,
    output logic                  busy
);

    localparam logic [FIRE_CNT_W-1:0] LIMIT     = FIRE_CNT_W'(FIRE_LIMIT);
    localparam logic [7:0]            HOLD_LOAD = 8'(HOLDOFF - 1);
    localparam logic [TMO_CNT_W-1:0]  TMO_LIMIT = TMO_CNT_W'(ACK_TIMEOUT);

    int_state_t             r_state;
    logic                   r_interrupt;
    logic                   r_busy;
    logic                   r_ack_timeout;
    logic [FIRE_CNT_W-1:0]  r_fire_count;
    logic [TMO_CNT_W-1:0]   r_tmo_cnt;
    logic [7:0]             r_hold_cnt;

    logic                   w_rise;
    logic                   w_ack;
    logic [TMO_CNT_W-1:0]   w_tmo_next;

    pc_rise_detect #(
        .TARGET_PC (TARGET_PC)
    ) u_pc_rise_detect (
        .clk    (clk),
        .reset  (reset),
        .i_pc   (macroscopic_pc),
        .o_rise (w_rise)
    );

    assign w_ack      = (|m_int_byteen) & word_match(m_int_addr, ACK_ADDR);
    assign w_tmo_next = r_tmo_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_interrupt   <= 1'b0;
            r_busy        <= 1'b0;
            r_ack_timeout <= 1'b0;
            r_fire_count  <= '0;
            r_tmo_cnt     <= '0;
            r_hold_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rise && (r_fire_count < LIMIT)) begin
                        r_state     <= S_ASSERT;
                        r_interrupt <= 1'b1;
                        r_busy      <= 1'b1;
                        if (r_fire_count != '1) r_fire_count <= r_fire_count + 1'b1;
                    end
                end
                S_ASSERT: begin
                    // Counter parks at the limit; the flag is sticky so it never needs to wrap.
                    if (r_tmo_cnt != TMO_LIMIT) r_tmo_cnt <= w_tmo_next;
                    if (w_tmo_next == TMO_LIMIT) r_ack_timeout <= 1'b1;
                    if (w_ack) begin
                        r_state     <= S_HOLDOFF;
                        r_interrupt <= 1'b0;
                        r_tmo_cnt   <= '0;
                        r_hold_cnt  <= HOLD_LOAD;
                    end
                end
                S_HOLDOFF: begin
                    if (r_hold_cnt == 8'd0) begin
                        r_busy  <= 1'b0;
                        r_state <= (r_fire_count == LIMIT) ? S_DONE : S_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                S_DONE: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign interrupt   = r_interrupt;
    assign busy        = r_busy;
    assign ack_timeout = r_ack_timeout;
    assign fire_count  = r_fire_count;

endmodule

// File: doc/int_responder.md
# int_responder

Device-side interrupt source for the P7 micro-system, at the other end of the CPU's interrupt-acknowledge protocol. Watches the CPU's `macroscopic_pc` and raises `interrupt` when execution reaches a programmed target. Holds the request until the CPU's handler writes the acknowledge address on the `m_int_*` bus. Then enforces a hold-off and re-arm before it can fire again, and flags handlers that never acknowledge.

## Interface
- `ACK_ADDR`, 32'h0000_7f20, word address the handler writes to acknowledge; bits [1:0] ignored.
- `TARGET_PC`, 32'h0000_3010, PC that triggers a request; bits [1:0] ignored.
- `FIRE_LIMIT`, 1, maximum requests per reset, range 0..255; 0 disables the block.
- `HOLDOFF`, 4, cycles after acknowledge before re-arming, range 1..255.
- `ACK_TIMEOUT`, 1024, cycles in ASSERT before `ack_timeout` sets, range 1..65535.

Ports:
- `clk`, input, 1, clock; all state updates on the rising edge.
- `reset`, input, 1, synchronous, active-high reset.
- `macroscopic_pc`, input, 32, CPU macroscopic PC.
- `m_int_addr`, input, 32, CPU interrupt-bus write address.
- `m_int_byteen`, input, 4, CPU interrupt-bus byte enables; a write occurs when any bit is set.
- `interrupt`, output, 1, registered interrupt request to the CPU.
- `fire_count`, output, 8, number of requests raised since reset; saturates at 255.
- `ack_timeout`, output, 1, sticky flag: a request went unacknowledged for `ACK_TIMEOUT` cycles.
- `busy`, output, 1, high in ASSERT or HOLDOFF.

## Operation
- `match` = (`macroscopic_pc[31:2]` == `TARGET_PC[31:2]`).
- `match_q` is `match` registered one cycle.
- `rise` = `match` & ~`match_q`. Only a rising match triggers, so a stalled PC sitting on the target fires once.
- `ack` = (|`m_int_byteen`) & (`m_int_addr[31:2]` == `ACK_ADDR[31:2]`).
- States:
  - IDLE: on `rise` and `fire_count` < `FIRE_LIMIT`, go to ASSERT and increment `fire_count` (saturating).
  - ASSERT: `interrupt`=1. The timeout counter increments every cycle. When it reaches `ACK_TIMEOUT`, `ack_timeout` sets and stays set until reset; the state does not change. On `ack`, go to HOLDOFF, clear the timeout counter, load the hold-off counter with `HOLDOFF`-1.
  - HOLDOFF: `interrupt`=0. The hold-off counter decrements. At 0: go to DONE if `fire_count` == `FIRE_LIMIT`, else go to IDLE.
  - DONE: terminal until reset; all inputs ignored.
- `ack` in IDLE, HOLDOFF or DONE is ignored; it is not counted and not remembered.
- `rise` in ASSERT or HOLDOFF is dropped, not queued.
- `rise` and `ack` in the same IDLE cycle: the `rise` wins and ASSERT is entered.
- `ack` and timeout reached in the same ASSERT cycle: the `ack` is taken and `ack_timeout` still sets.
- `FIRE_LIMIT`=0: the block never leaves IDLE and `interrupt` stays 0.
- `busy` = state ∈ {ASSERT, HOLDOFF}.

## Timing
- Reset values: state IDLE, `interrupt`=0, `fire_count`=0, `ack_timeout`=0, `busy`=0, `match_q`=0, both counters 0.
- `reset` overrides everything in the same edge, including mid-ASSERT: `interrupt` is 0 in the cycle after `reset` is sampled high.
- `rise` sampled at edge N: `interrupt`=1 and `fire_count` updated from edge N; visible during cycle N+1.
- `ack` sampled at edge M: `interrupt`=0 from edge M.
- Minimum high time of `interrupt` is 1 cycle (`ack` in the first ASSERT cycle).
- After `ack` at edge M, the earliest next trigger is a `rise` sampled at edge M+`HOLDOFF`+1. This also requires `match` to have been low at some earlier sampled edge.
- `ack_timeout` sets at the edge where the ASSERT-cycle count equals `ACK_TIMEOUT`.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package `int_pkg`:
  - state enum {IDLE, ASSERT, HOLDOFF, DONE}, 2 bits;
  - `INT_ACK_ADDR_DEFAULT` = 32'h7f20, also used by the bridge decode;
  - widths: `FIRE_CNT_W`=8, `TMO_CNT_W`=16.
- One sub-module is natural: `pc_rise_detect`, which registers the target comparison and outputs `rise`.
- The FSM and both counters live in `int_responder`.

## Test plan
- Basic fire: PC steps 0x3008→0x300c→0x3010→0x3014; `ack` 5 cycles later → `interrupt` high for exactly those cycles; `fire_count`=1; state DONE; `busy`=0 after 4 hold-off cycles.
- Stalled PC / low bits: PC held at 0x3012 for 10 cycles with `FIRE_LIMIT`=3 → a single request; `fire_count`=1.
- Spurious writes: writes to 0x7f24, writes to 0x7f20 with `m_int_byteen`=0, and an `ack` while in IDLE → none clears or affects `interrupt`; a later `ack` to 0x7f23 with `m_int_byteen`=4'b0001 clears it.
- Re-arm: `FIRE_LIMIT`=2; second `rise` during HOLDOFF is dropped; third `rise` 5 cycles after the `ack` fires → `fire_count`=2; state DONE after the second `ack`.
- Timeout: no `ack`, `ACK_TIMEOUT`=16 → `ack_timeout` rises 16 cycles after `interrupt` rises while `interrupt` stays 1; a later `ack` clears `interrupt` but `ack_timeout` stays 1.
- Reset mid-ASSERT: `reset` pulsed with `interrupt`=1 → all outputs return to 0 the next cycle; a fresh `rise` fires again.
